// File: rtl/seg7_capture.sv
// Passive 7-segment bus receiver: settles, decodes and latches multiplexed digits.
// Optional decimal-point capture when SEG7_CAPTURE_DP_EN is defined.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_i,
  input  logic [6:0]            seg_i,
`ifdef SEG7_CAPTURE_DP_EN
  input  logic                  dp_i,
`endif
  input  logic                  clear_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     digit_valid_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic                  err_o,
`ifdef SEG7_CAPTURE_DP_EN
  output logic [DIGITS-1:0]     dp_o,
`endif
  output logic                  frame_o
);

`ifdef SEG7_CAPTURE_DP_EN
  localparam int DPW = 1;
`else
  localparam int DPW = 0;
`endif
  localparam int W  = DIGITS + 7 + DPW;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HELD   = 2'd2;

  logic [W-1:0] raw;
`ifdef SEG7_CAPTURE_DP_EN
  assign raw = {an_i, dp_i, seg_i};
`else
  assign raw = {an_i, seg_i};
`endif

  logic [W-1:0] sync1_q, sync2_q, prev_q;
  logic [1:0]   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         commit;

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                err_q, err_d;
  logic                frame_q, frame_d;
`ifdef SEG7_CAPTURE_DP_EN
  logic [DIGITS-1:0]   dp_q, dp_d;
`endif

  logic [DIGITS-1:0] an_low;
  logic [6:0]        seg_s;
  logic              onehot;
  logic [5:0]        dec;

  assign an_low = ~sync2_q[W-1 -: DIGITS];
  assign seg_s  = sync2_q[6:0];
  assign onehot = (an_low != '0) &&
                  ((an_low & (an_low - DIGITS'(1))) == '0);

  // {legal, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] sg);
    logic [5:0] r;
    case (sg)
      7'b1000000: r = 6'b10_0000;
      7'b1111001: r = 6'b10_0001;
      7'b0100100: r = 6'b10_0010;
      7'b0110000: r = 6'b10_0011;
      7'b0011001: r = 6'b10_0100;
      7'b0010010: r = 6'b10_0101;
      7'b0000010: r = 6'b10_0110;
      7'b1111000: r = 6'b10_0111;
      7'b0000000: r = 6'b10_1000;
      7'b0010000,
      7'b0011000: r = 6'b10_1001;
      7'b0001000: r = 6'b10_1010;
      7'b0000011: r = 6'b10_1011;
      7'b1000110: r = 6'b10_1100;
      7'b0100001: r = 6'b10_1101;
      7'b0000110: r = 6'b10_1110;
      7'b0001110: r = 6'b10_1111;
      7'b1111111: r = 6'b11_0000;
      default:    r = 6'b00_0000;
    endcase
    return r;
  endfunction

  assign dec = decode(seg_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != prev_q) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (sync2_q != prev_q) begin
          cnt_d = CW'(1);
        end else if (cnt_q == CW'(STABLE_CYCLES)) begin
          commit  = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (sync2_q != prev_q) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    blank_d = blank_q;
    err_d   = err_q;
    seen_d  = seen_q;
    frame_d = 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
    dp_d    = dp_q;
`endif
    if (clear_i) begin
      value_d = '0;
      valid_d = '0;
      blank_d = '0;
      err_d   = 1'b0;
      seen_d  = '0;
`ifdef SEG7_CAPTURE_DP_EN
      dp_d    = '0;
`endif
    end else if (commit && onehot) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (an_low[k]) begin
          if (dec[5]) begin
            value_d[4*k +: 4] = dec[3:0];
            valid_d[k]        = 1'b1;
            blank_d[k]        = dec[4];
          end else begin
            valid_d[k] = 1'b0;
            blank_d[k] = 1'b0;
            err_d      = 1'b1;
          end
`ifdef SEG7_CAPTURE_DP_EN
          dp_d[k] = ~sync2_q[7];
`endif
        end
      end
      if (&(seen_q | an_low)) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_q | an_low;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= '0;
      blank_q <= '0;
      err_q   <= 1'b0;
      seen_q  <= '0;
      frame_q <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
      dp_q    <= '0;
`endif
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
`ifdef SEG7_CAPTURE_DP_EN
      dp_q    <= dp_d;
`endif
    end
  end

  assign value_o       = value_q;
  assign digit_valid_o = valid_q;
  assign blank_o       = blank_q;
  assign err_o         = err_q;
  assign frame_o       = frame_q;
`ifdef SEG7_CAPTURE_DP_EN
  assign dp_o          = dp_q;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: scoreboard of expected output words.
// Expected values come from a small per-digit model kept in the bench.
module tb_seg7_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic        clear = 1'b0;
  logic [15:0] value_o;
  logic [3:0]  digit_valid_o;
  logic [3:0]  blank_o;
  logic        err_o;
  logic        frame_o;
`ifdef SEG7_CAPTURE_DP_EN
  logic        dp = 1'b1;
  logic [3:0]  dp_o;
`endif

  seg7_capture #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .an_i          (an),
    .seg_i         (seg),
`ifdef SEG7_CAPTURE_DP_EN
    .dp_i          (dp),
`endif
    .clear_i       (clear),
    .value_o       (value_o),
    .digit_valid_o (digit_valid_o),
    .blank_o       (blank_o),
    .err_o         (err_o),
`ifdef SEG7_CAPTURE_DP_EN
    .dp_o          (dp_o),
`endif
    .frame_o       (frame_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  always @(negedge clk) if (frame_o === 1'b1) frames++;

  typedef struct {
    string       tag;
    logic [25:0] w;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_val;
  logic [3:0]  m_vld;
  logic [3:0]  m_blk;
  logic        m_err;

  task automatic push(input string tag, input logic fr);
    exp_t e;
    e.tag = tag;
    e.w   = {m_val, m_vld, m_blk, m_err, fr};
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [25:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry");
    end else begin
      e   = sb.pop_front();
      obs = {value_o, digit_valid_o, blank_o, err_o, frame_o};
      assert (obs === e.w) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.w);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s,
                       input int n);
    an  = a;
    seg = s;
    cyc(n);
  endtask

  task automatic gap();
    drive(4'hF, seg, 2);
  endtask

  logic [6:0] codes [4];
  logic [3:0] nibs  [4];

  initial begin
    codes = '{7'b1000000, 7'b1111001, 7'b0001000, 7'b0001110};
    nibs  = '{4'h0, 4'h1, 4'hA, 4'hF};
    m_val = '0; m_vld = '0; m_blk = '0; m_err = 1'b0;

    cyc(2);
    push("reset_held", 1'b0);
    check();
    rst_n = 1'b1;
    push("reset_release", 1'b0);
    check();

    // first pattern after reset: digit 0 shows 3
    push("t1_before_latency", 1'b0);
    drive(4'b1110, 7'b0110000, 10);
    check();
    m_val[3:0] = 4'h3; m_vld[0] = 1'b1;
    push("t1_commit", 1'b0);
    cyc(1);
    check();
    cyc(10);

    for (int k = 0; k < 4; k++) begin
      gap();
      push($sformatf("t2_pre_d%0d", k), 1'b0);
      drive(~(4'b0001 << k), codes[k], 10);
      check();
      m_val[4*k +: 4] = nibs[k];
      m_vld[k] = 1'b1;
      push($sformatf("t2_commit_d%0d", k), k == 3);
      cyc(1);
      check();
      push($sformatf("t2_after_d%0d", k), 1'b0);
      cyc(1);
      check();
      cyc(8);
    end

    // glitch on digit 2 restarts settling
    gap();
    drive(4'b1011, 7'b0110000, 4);
    for (int i = 0; i < 5; i++) begin
      seg = (i % 2 == 0) ? 7'b0110001 : 7'b0110000;
      cyc(1);
    end
    push("t3_pre", 1'b0);
    drive(4'b1011, 7'b0110000, 10);
    check();
    m_val[11:8] = 4'h3;
    push("t3_commit", 1'b0);
    cyc(1);
    check();
    cyc(10);

    // illegal on digit 1, then legal
    gap();
    push("t4_illegal_pre", 1'b0);
    drive(4'b1101, 7'b1010101, 10);
    check();
    m_vld[1] = 1'b0; m_err = 1'b1;
    push("t4_illegal", 1'b0);
    cyc(1);
    check();
    cyc(10);
    gap();
    drive(4'b1101, 7'b0100100, 11);
    m_val[7:4] = 4'h2; m_vld[1] = 1'b1;
    push("t4_legal_err_sticky", 1'b0);
    check();
    cyc(10);

    // blank on digit 0
    gap();
    drive(4'b1110, 7'b1111111, 11);
    m_val[3:0] = 4'h0; m_blk[0] = 1'b1;
    push("t5_blank", 1'b0);
    check();
    cyc(10);

    // clear on the digit 1 commit edge
    gap();
    drive(4'b1101, 7'b1111001, 10);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    m_val = '0; m_vld = '0; m_blk = '0; m_err = 1'b0;
    push("t5_clear", 1'b0);
    check();
    push("t5_commit_lost", 1'b0);
    cyc(12);
    check();

    // multiple anodes low are ignored
    gap();
    drive(4'b0111, 7'b0000000, 11);
    m_val[15:12] = 4'h8; m_vld[3] = 1'b1;
    push("t6_digit3", 1'b0);
    check();
    cyc(10);
    drive(4'b1100, 7'b0000000, 30);
    push("t6_two_anodes", 1'b0);
    check();

    // async reset mid-settle
    drive(4'b1110, 7'b1111001, 5);
    rst_n = 1'b0;
    #1;
    m_val = '0; m_vld = '0; m_blk = '0; m_err = 1'b0;
    push("t6_async_reset", 1'b0);
    check();
    @(negedge clk);
    rst_n = 1'b1;
    push("t6_post_reset_pre", 1'b0);
    cyc(10);
    check();
    m_val[3:0] = 4'h1; m_vld[0] = 1'b1;
    push("t6_post_reset_commit", 1'b0);
    cyc(1);
    check();

    checks++;
    assert (frames == 1) else begin
      errors++;
      $error("FAIL frame_count: observed %0d expected 1", frames);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
